// File: rtl/dahua_cap.sv
// Parallel-camera capture front-end: FV/LV-qualified 16-bit pixels re-emitted as an
// AXI4-Stream video stream (tuser = start of frame, tlast = end of line) via an FWFT FIFO.
module dahua_cap #(
    parameter int WIDTH      = 480,
    parameter int HEIGTH     = 640,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        pclk,
    input  logic        resetn,
    input  logic [15:0] D_IN,
    input  logic        FV,
    input  logic        LV,
    output logic        m_aclk,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [15:0] data;
    } entry_t;

    logic          fv_q, fv_prev_q, lv_q, lv_prev_q;
    logic [15:0]   d_q;
    logic          armed_q, armed_d;
    logic          sof_q, sof_d, sof_now;
    logic          drop_q, drop_d;
    logic [CW-1:0] col_q, col_d, col_now;
    logic [RW-1:0] row_q, row_d;
    logic          pix_vld_q, pix_vld_d;
    entry_t        pix_q, pix_d, head;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    entry_t        mem [FIFO_DEPTH];

    logic fv_rise, lv_rise, lv_fall, sample, in_line;
    logic empty, full, rd_en, push, wr_en, overflow;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fv_rise  = fv_q & ~fv_prev_q;
        lv_rise  = lv_q & ~lv_prev_q;
        lv_fall  = ~lv_q & lv_prev_q;

        // A frame start takes effect for a pixel sampled in the same cycle.
        armed_d  = armed_q | fv_rise;
        sof_now  = sof_q | fv_rise;
        col_now  = (fv_rise || lv_rise) ? '0 : col_q;
        sample   = fv_q & lv_q & armed_d & (fv_rise | ~drop_q);
        in_line  = col_now < CW'(WIDTH);

        pix_vld_d  = sample & in_line;
        pix_d.tuser = sof_now;
        pix_d.tlast = (col_now == CW'(WIDTH - 1));
        pix_d.data  = d_q;
        col_d      = (sample && in_line) ? col_now + 1'b1 : col_now;
        sof_d      = pix_vld_d ? 1'b0 : sof_now;

        row_d = row_q;
        if (fv_rise)
            row_d = '0;
        else if (lv_fall && fv_q && row_q != RW'(HEIGTH - 1))
            row_d = row_q + 1'b1;

        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en    = ~empty & m_axis_tready;
        push     = pix_vld_q & ~drop_q;
        // A read in the same cycle frees a slot, so a full FIFO can still accept.
        wr_en    = push & (~full | rd_en);
        overflow = push & full & ~rd_en;
        drop_d   = fv_rise ? 1'b0 : (drop_q | overflow);

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        head     = mem[rd_ptr_q[AW-1:0]];
    end

    assign m_aclk        = pclk;
    assign m_axis_tvalid = ~empty;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = empty ? '0 : head;

    // NOTE: the pin registers are deliberately not reset: they keep tracking FV/LV through
    // reset, so a level held across reset release is never mistaken for a rising edge.
    always_ff @(posedge pclk) begin
        fv_q      <= FV;
        fv_prev_q <= fv_q;
        lv_q      <= LV;
        lv_prev_q <= lv_q;
        d_q       <= D_IN;
    end

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge pclk) begin
        if (wr_en)
            mem[wr_ptr_q[AW-1:0]] <= pix_q;
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge pclk) begin
        if (resetn) begin
            armed_q   <= 1'b0;
            sof_q     <= 1'b0;
            drop_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            pix_vld_q <= 1'b0;
            pix_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            armed_q   <= armed_d;
            sof_q     <= sof_d;
            drop_q    <= drop_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pix_vld_q <= pix_vld_d;
            pix_q     <= pix_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // The line counter is kept for frame bookkeeping but drives no output.
    logic unused_row;
    assign unused_row = ^row_q;

endmodule

// File: tb/tb_dahua_cap.sv
// Bench for dahua_cap: two instances (WIDTH=4/depth 32 and WIDTH=8/depth 4) share the
// camera pins; per-instance queues hold the expected beats {tuser, tlast, data}.
module tb_dahua_cap;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_in = '0;
    logic        fv = 1'b0;
    logic        lv = 1'b0;

    logic        aclk_a, tvalid_a, tuser_a, tlast_a;
    logic        tready_a = 1'b0;
    logic [15:0] tdata_a;
    logic        aclk_b, tvalid_b, tuser_b, tlast_b;
    logic        tready_b = 1'b0;
    logic [15:0] tdata_b;

    logic [17:0] q_a[$];
    logic [17:0] q_b[$];
    bit          mon_a = 1'b0;
    bit          mon_b = 1'b0;
    bit          bp_mode = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dahua_cap #(.WIDTH(4), .HEIGTH(2), .FIFO_DEPTH(32)) dut_a (
        .pclk(clk), .resetn(rst), .D_IN(d_in), .FV(fv), .LV(lv),
        .m_aclk(aclk_a), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
        .m_axis_tready(tready_a), .m_axis_tuser(tuser_a), .m_axis_tlast(tlast_a)
    );

    dahua_cap #(.WIDTH(8), .HEIGTH(2), .FIFO_DEPTH(4)) dut_b (
        .pclk(clk), .resetn(rst), .D_IN(d_in), .FV(fv), .LV(lv),
        .m_aclk(aclk_b), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
        .m_axis_tready(tready_b), .m_axis_tuser(tuser_b), .m_axis_tlast(tlast_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every valid cycle must present the queue head (covers order and stall stability).
    always @(negedge clk) begin
        if (mon_a) begin
            if (tvalid_a) begin
                check("a_beat_pending", 32'(q_a.size() > 0), 1);
                if (q_a.size() > 0) begin
                    check("a_beat", {14'b0, tuser_a, tlast_a, tdata_a}, {14'b0, q_a[0]});
                    if (tready_a) void'(q_a.pop_front());
                end
            end else
                check("a_idle_zero", {14'b0, tuser_a, tlast_a, tdata_a}, 0);
        end
    end

    always @(negedge clk) begin
        if (mon_b) begin
            if (tvalid_b) begin
                check("b_beat_pending", 32'(q_b.size() > 0), 1);
                if (q_b.size() > 0) begin
                    check("b_beat", {14'b0, tuser_b, tlast_b, tdata_b}, {14'b0, q_b[0]});
                    if (tready_b) void'(q_b.pop_front());
                end
            end else
                check("b_idle_zero", {14'b0, tuser_b, tlast_b, tdata_b}, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) tready_a = ~tready_a;
    endtask

    task automatic line(input logic [15:0] base, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            lv   = 1'b1;
            d_in = base + 16'(i);
            tick();
        end
        lv   = 1'b0;
        d_in = '0;
        repeat (gap) tick();
    endtask

    task automatic frame_start();
        fv = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        fv = 1'b0;
        repeat (3) tick();
    endtask

    task automatic expect_line(input int which, input logic [15:0] base, input int n,
                               input int width, input bit sof);
        logic [17:0] e;
        for (int i = 0; i < n && i < width; i++) begin
            e = {sof && (i == 0), i == width - 1, base + 16'(i)};
            if (which == 0) q_a.push_back(e);
            else            q_b.push_back(e);
        end
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        check((which == 0) ? "a_drain" : "b_drain",
              (which == 0) ? q_a.size() : q_b.size(), 0);
        repeat (6) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset held with FV=LV=1 and toggling data: nothing may come out.
        fv = 1'b1;
        lv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_in = (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
            tick();
            mon_a = 1'b1;
            check("rst_tvalid_a", tvalid_a, 0);
            check("rst_tvalid_b", tvalid_b, 0);
            check("rst_tdata_a", tdata_a, 0);
        end
        rst      = 1'b0;
        tready_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_in = 16'h1000 + 16'(i);
            tick();
            check("post_rst_no_frame_a", tvalid_a, 0);
            check("post_rst_no_frame_b", tvalid_b, 0);
        end
        check("aclk_copy_hi", aclk_a, clk);
        fv = 1'b0;
        lv = 1'b0;
        repeat (3) tick();

        // Single frame, tready=1, with exact first-beat latency.
        frame_start();
        expect_line(0, 16'h0001, 4, 4, 1'b1);
        expect_line(0, 16'h0005, 4, 4, 1'b0);
        lv = 1'b1; d_in = 16'h0001; tick();
        check("lat_edge_n", tvalid_a, 0);
        d_in = 16'h0002; tick();
        check("lat_edge_n1", tvalid_a, 0);
        d_in = 16'h0003; tick();
        check("lat_edge_n2_valid", tvalid_a, 1);
        check("lat_edge_n2_data", {tuser_a, tdata_a}, {1'b1, 16'h0001});
        d_in = 16'h0004; tick();
        lv = 1'b0; d_in = '0;
        repeat (3) tick();
        line(16'h0005, 4, 3);
        frame_end();
        drain(0);

        // Backpressure: tready toggles every cycle.
        bp_mode = 1'b1;
        frame_start();
        expect_line(0, 16'h0001, 4, 4, 1'b1);
        expect_line(0, 16'h0005, 4, 4, 1'b0);
        line(16'h0001, 4, 3);
        line(16'h0005, 4, 3);
        frame_end();
        drain(0);
        bp_mode  = 1'b0;
        tready_a = 1'b1;

        // Long line truncated at WIDTH, then a short line without tlast.
        frame_start();
        expect_line(0, 16'h0011, 6, 4, 1'b1);
        line(16'h0011, 6, 3);
        expect_line(0, 16'h0021, 2, 4, 1'b0);
        line(16'h0021, 2, 3);
        frame_end();
        drain(0);

        // Reset mid-line with three entries buffered and tready low.
        tready_a = 1'b0;
        frame_start();
        expect_line(0, 16'h0071, 3, 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            lv   = 1'b1;
            d_in = 16'h0071 + 16'(i);
            tick();
        end
        check("mr_pre_valid", tvalid_a, 1);
        mon_a = 1'b0;
        q_a.delete();
        rst  = 1'b1;
        d_in = 16'h0076;
        tick();
        rst   = 1'b0;
        mon_a = 1'b1;
        check("mr_tvalid_next", tvalid_a, 0);
        tready_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_in = 16'h0077 + 16'(i);
            tick();
            check("mr_no_output", tvalid_a, 0);
        end
        lv = 1'b0;
        frame_end();
        frame_start();
        expect_line(0, 16'h0081, 4, 4, 1'b1);
        line(16'h0081, 4, 3);
        frame_end();
        drain(0);

        // Overflow on the depth-4 instance.
        mon_a    = 1'b0;
        tready_a = 1'b0;
        tready_b = 1'b0;
        do_reset();
        mon_b = 1'b1;
        frame_start();
        expect_line(1, 16'h0031, 4, 8, 1'b1);
        line(16'h0031, 8, 3);
        line(16'h0041, 8, 3);
        frame_end();
        check("ovf_hold_valid", tvalid_b, 1);
        check("ovf_hold_data", tdata_b, 16'h0031);
        check("aclk_copy_b", aclk_b, clk);
        tready_b = 1'b1;
        drain(1);
        frame_start();
        expect_line(1, 16'h0051, 8, 8, 1'b1);
        line(16'h0051, 8, 3);
        frame_end();
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
